// File: rtl/invaders_pkg.sv
// rtl/invaders_pkg.sv - shared constants, sprite bitmap, row colours and cell index type for the invader matrix
package invaders_pkg;

    localparam int ROWS        = 4;
    localparam int COLS        = 10;
    localparam int CELL_W      = 32;
    localparam int CELL_H      = 32;
    localparam int ANIM_FRAMES = 15;

    localparam int SPRITE_W = CELL_W;
    localparam int SPRITE_H = CELL_H;
    localparam int CELL_XB  = $clog2(CELL_W);
    localparam int CELL_YB  = $clog2(CELL_H);
    localparam int ROW_W    = $clog2(ROWS);
    localparam int COL_W    = $clog2(COLS);
    localparam int NCELLS   = ROWS * COLS;
    localparam int IDX_W    = $clog2(NCELLS);
    localparam int CNT_W    = $clog2(NCELLS + 1);
    localparam int ANIM_W   = $clog2(ANIM_FRAMES);

    localparam logic [7:0] TRANSPARENT_COLOUR = 8'hFF;

    // Row 0 red, row 1 green, row 2 blue, row 3 yellow (RRRGGGBB).
    localparam logic [ROWS-1:0][7:0] ROW_COLOUR = {8'hFC, 8'h03, 8'h1C, 8'hE0};

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } cell_idx_t;

    typedef logic [1:0][SPRITE_H-1:0][SPRITE_W-1:0] sprite_t;

    // Frame 0 is a wide, short body; frame 1 is a narrow, tall body.
    function automatic sprite_t build_sprite();
        sprite_t s;
        s = '0;
        for (int y = 0; y < SPRITE_H; y++) begin
            for (int x = 0; x < SPRITE_W; x++) begin
                s[0][y][x] = (y >= 8) && (y <= 23) && (x >= 4) && (x <= 27);
                s[1][y][x] = (y >= 4) && (y <= 27) && (x >= 8) && (x <= 23);
            end
        end
        return s;
    endfunction

    localparam sprite_t SPRITE = build_sprite();

    // Flat alive-bit index of a cell, row-major.
    function automatic logic [IDX_W-1:0] cell_index(cell_idx_t c);
        return IDX_W'(c.row * COLS + c.col);
    endfunction

endpackage

// File: rtl/invaders_matrix_draw_if.sv
// rtl/invaders_matrix_draw_if.sv - pixel/control inputs and draw/status outputs of the invader matrix
interface invaders_matrix_draw_if;
    import invaders_pkg::*;

    logic                    startOfFrame;
    logic [10:0]             pixelX;
    logic [10:0]             pixelY;
    logic signed [10:0]      topLeftX;
    logic signed [10:0]      topLeftY;
    logic                    hit;
    logic                    newWave;
    logic                    drawingRequest;
    logic [7:0]              RGBout;
    logic [CNT_W-1:0]        aliveCount;
    logic                    allDead;
    logic [COL_W-1:0]        leftCol;
    logic [COL_W-1:0]        rightCol;

    modport slave (
        input  startOfFrame, pixelX, pixelY, topLeftX, topLeftY, hit, newWave,
        output drawingRequest, RGBout, aliveCount, allDead, leftCol, rightCol
    );

    modport master (
        output startOfFrame, pixelX, pixelY, topLeftX, topLeftY, hit, newWave,
        input  drawingRequest, RGBout, aliveCount, allDead, leftCol, rightCol
    );
endinterface

// File: rtl/invaders_alive_matrix.sv
// rtl/invaders_alive_matrix.sv - alive bits, one-kill-per-frame lock, live count and live column edges
module invaders_alive_matrix
    import invaders_pkg::*;
(
    input  logic              clk,
    input  logic              resetN,
    input  logic              i_start_of_frame,
    input  logic              i_hit,
    input  logic              i_new_wave,
    input  logic              i_drawing_request,
    input  cell_idx_t         i_hit_cell,
    output logic [NCELLS-1:0] o_alive,
    output logic [CNT_W-1:0]  o_alive_count,
    output logic              o_all_dead,
    output logic [COL_W-1:0]  o_left_col,
    output logic [COL_W-1:0]  o_right_col
);

    logic [NCELLS-1:0] r_alive;
    logic [CNT_W-1:0]  r_alive_count;
    logic              r_all_dead;
    logic              r_hit_lock;
    logic [COL_W-1:0]  r_left_col;
    logic [COL_W-1:0]  r_right_col;

    logic [COLS-1:0]   w_col_or;
    logic              w_any_alive;
    logic [COL_W-1:0]  w_left;
    logic [COL_W-1:0]  w_right;
    logic              w_accept;
    logic [IDX_W-1:0]  w_kill_idx;

    // A hit only counts on a drawn (hence live) pixel, once per frame.
    assign w_accept   = i_hit && !r_hit_lock && i_drawing_request && !i_new_wave;
    assign w_kill_idx = cell_index(i_hit_cell);

    // Per-column OR of alive bits and the outermost live columns.
    always_comb begin
        w_col_or = '0;
        w_left   = '0;
        w_right  = '0;
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                w_col_or[c] = w_col_or[c] | r_alive[r*COLS + c];
            end
        end
        for (int c = COLS - 1; c >= 0; c--) begin
            if (w_col_or[c]) w_left = COL_W'(c);
        end
        for (int c = 0; c < COLS; c++) begin
            if (w_col_or[c]) w_right = COL_W'(c);
        end
    end
    assign w_any_alive = |w_col_or;

    // Kill, lock, count and frame-stable column edges; newWave overrides all.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_alive       <= '1;
            r_alive_count <= CNT_W'(NCELLS);
            r_all_dead    <= 1'b0;
            r_hit_lock    <= 1'b0;
            r_left_col    <= '0;
            r_right_col   <= COL_W'(COLS - 1);
        end else if (i_new_wave) begin
            r_alive       <= '1;
            r_alive_count <= CNT_W'(NCELLS);
            r_all_dead    <= 1'b0;
            r_hit_lock    <= 1'b0;
            r_left_col    <= '0;
            r_right_col   <= COL_W'(COLS - 1);
        end else begin
            if (w_accept) begin
                r_alive[w_kill_idx] <= 1'b0;
                r_alive_count       <= r_alive_count - 1'b1;
                r_all_dead          <= (r_alive_count == CNT_W'(1));
                r_hit_lock          <= 1'b1;
            end else if (i_start_of_frame) begin
                r_hit_lock <= 1'b0;
            end
            // With nothing alive the edges keep their last values.
            if (i_start_of_frame && w_any_alive) begin
                r_left_col  <= w_left;
                r_right_col <= w_right;
            end
        end
    end

    assign o_alive       = r_alive;
    assign o_alive_count = r_alive_count;
    assign o_all_dead    = r_all_dead;
    assign o_left_col    = r_left_col;
    assign o_right_col   = r_right_col;

endmodule

// File: rtl/invaders_matrix_draw.sv
// rtl/invaders_matrix_draw.sv - maps VGA pixels onto the invader matrix and draws live sprite pixels
module invaders_matrix_draw
    import invaders_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetN,
    invaders_matrix_draw_if.slave vga
);

    logic signed [11:0] w_off_x;
    logic signed [11:0] w_off_y;
    logic               w_inside;
    cell_idx_t          w_cell;
    logic [CELL_XB-1:0] w_in_x;
    logic [CELL_YB-1:0] w_in_y;
    logic [NCELLS-1:0]  w_alive;
    logic               w_alive_bit;
    logic               w_draw;

    logic               r_drawing_request;
    logic [7:0]         r_rgb;
    cell_idx_t          r_hit_cell;
    logic [ANIM_W-1:0]  r_frame_cnt;
    logic               r_anim_frame;

    // Signed 12-bit offsets so a negative top-left still maps correctly.
    assign w_off_x = $signed({1'b0, vga.pixelX}) - $signed({vga.topLeftX[10], vga.topLeftX});
    assign w_off_y = $signed({1'b0, vga.pixelY}) - $signed({vga.topLeftY[10], vga.topLeftY});

    assign w_inside = !w_off_x[11] && (w_off_x[10:0] < 11'(COLS * CELL_W)) &&
                      !w_off_y[11] && (w_off_y[10:0] < 11'(ROWS * CELL_H));

    assign w_cell.row = w_off_y[CELL_YB + ROW_W - 1:CELL_YB];
    assign w_cell.col = w_off_x[CELL_XB + COL_W - 1:CELL_XB];
    assign w_in_x     = w_off_x[CELL_XB-1:0];
    assign w_in_y     = w_off_y[CELL_YB-1:0];

    // Alive lookup only when the cell index is meaningful.
    always_comb begin
        w_alive_bit = 1'b0;
        if (w_inside) w_alive_bit = w_alive[cell_index(w_cell)];
    end

    assign w_draw = w_inside && w_alive_bit && SPRITE[r_anim_frame][w_in_y][w_in_x];

    // One-clock pixel pipeline: draw flag, colour and the cell it came from.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_drawing_request <= 1'b0;
            r_rgb             <= TRANSPARENT_COLOUR;
            r_hit_cell        <= '0;
        end else begin
            r_drawing_request <= w_draw;
            r_rgb             <= w_draw ? ROW_COLOUR[w_cell.row] : TRANSPARENT_COLOUR;
            r_hit_cell        <= w_cell;
        end
    end

    // Sprite animation: toggle the frame every ANIM_FRAMES frame starts.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_frame_cnt  <= '0;
            r_anim_frame <= 1'b0;
        end else if (vga.newWave) begin
            r_frame_cnt  <= '0;
            r_anim_frame <= 1'b0;
        end else if (vga.startOfFrame) begin
            if (r_frame_cnt == ANIM_W'(ANIM_FRAMES - 1)) begin
                r_frame_cnt  <= '0;
                r_anim_frame <= ~r_anim_frame;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    invaders_alive_matrix u_alive (
        .clk               (clk),
        .resetN            (resetN),
        .i_start_of_frame  (vga.startOfFrame),
        .i_hit             (vga.hit),
        .i_new_wave        (vga.newWave),
        .i_drawing_request (r_drawing_request),
        .i_hit_cell        (r_hit_cell),
        .o_alive           (w_alive),
        .o_alive_count     (vga.aliveCount),
        .o_all_dead        (vga.allDead),
        .o_left_col        (vga.leftCol),
        .o_right_col       (vga.rightCol)
    );

    assign vga.drawingRequest = r_drawing_request;
    assign vga.RGBout         = r_rgb;

endmodule

// File: tb/tb_invaders_matrix_draw.sv
// tb/tb_invaders_matrix_draw.sv - directed self-checking bench for invaders_matrix_draw
module tb_invaders_matrix_draw;

    logic clk = 1'b0;
    logic resetN;
    always #5 clk = ~clk;

    invaders_matrix_draw_if vga ();

    invaders_matrix_draw dut (
        .clk    (clk),
        .resetN (resetN),
        .vga    (vga)
    );

    int nvec = 0;
    int nerr = 0;
    int tlx  = 33;
    int tly  = 32;
    int exp_cnt;
    bit alive_m [4][10];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input int r, input int c, input int x, input int y);
        vga.pixelX = 11'(tlx + c*32 + x);
        vga.pixelY = 11'(tly + r*32 + y);
    endtask

    task automatic sof();
        vga.startOfFrame = 1'b1;
        step();
        vga.startOfFrame = 1'b0;
    endtask

    task automatic model_reset();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 10; c++)
                alive_m[r][c] = 1'b1;
        exp_cnt = 40;
    endtask

    // New frame, aim at an opaque pixel of the cell in both sprite frames, hit one clock.
    task automatic kill(input int r, input int c);
        sof();
        set_pix(r, c, 12, 12);
        step();
        vga.hit = 1'b1;
        step();
        vga.hit = 1'b0;
        alive_m[r][c] = 1'b0;
        exp_cnt--;
    endtask

    initial begin
        resetN           = 1'b0;
        vga.startOfFrame = 1'b0;
        vga.hit          = 1'b0;
        vga.newWave      = 1'b0;
        vga.topLeftX     = 11'(tlx);
        vga.topLeftY     = 11'(tly);
        vga.pixelX       = '0;
        vga.pixelY       = '0;
        model_reset();
        repeat (3) step();

        // Reset state
        chk("rst_draw",  vga.drawingRequest, 0);
        chk("rst_rgb",   vga.RGBout, 8'hFF);
        chk("rst_cnt",   vga.aliveCount, 40);
        chk("rst_dead",  vga.allDead, 0);
        chk("rst_left",  vga.leftCol, 0);
        chk("rst_right", vga.rightCol, 9);
        @(negedge clk);
        resetN = 1'b1;
        step();

        // 1: opaque frame-0 pixel in cell (0,0)
        set_pix(0, 0, 5, 9);
        step();
        chk("t1_draw", vga.drawingRequest, 1);
        chk("t1_rgb",  vga.RGBout, 8'hE0);
        chk("t1_cnt",  vga.aliveCount, 40);
        set_pix(0, 0, 0, 0);
        step();
        chk("t1_transp_draw", vga.drawingRequest, 0);
        chk("t1_transp_rgb",  vga.RGBout, 8'hFF);
        set_pix(2, 4, 10, 10);
        step();
        chk("t1_row2_rgb", vga.RGBout, 8'h03);

        // 2: edges of the matrix and a negative top-left
        vga.pixelX = 11'd32; vga.pixelY = 11'd41;
        step();
        chk("t2_left_out", vga.drawingRequest, 0);
        vga.pixelX = 11'd353;
        step();
        chk("t2_right_out", vga.drawingRequest, 0);
        chk("t2_right_rgb", vga.RGBout, 8'hFF);
        vga.pixelX = 11'd326;
        step();
        chk("t2_last_col", vga.drawingRequest, 1);
        vga.pixelY = 11'(tly + 128 + 9);
        step();
        chk("t2_below", vga.drawingRequest, 0);
        vga.topLeftX = -11'sd10;
        vga.pixelX = 11'd0; vga.pixelY = 11'd41;
        step();
        chk("t2_neg_draw", vga.drawingRequest, 1);
        chk("t2_neg_rgb",  vga.RGBout, 8'hE0);
        vga.pixelX = 11'd310;
        step();
        chk("t2_neg_right_out", vga.drawingRequest, 0);
        vga.topLeftX = 11'(tlx);

        // 3: held hit kills exactly one cell per frame
        set_pix(1, 3, 12, 12);
        step();
        chk("t3_pre_draw", vga.drawingRequest, 1);
        vga.hit = 1'b1;
        repeat (5) step();
        vga.hit = 1'b0;
        alive_m[1][3] = 1'b0;
        exp_cnt--;
        chk("t3_cnt_39", vga.aliveCount, 39);
        step();
        chk("t3_dead_cell", vga.drawingRequest, 0);
        set_pix(1, 4, 12, 12);
        step();
        chk("t3_neighbour", vga.drawingRequest, 1);
        set_pix(2, 5, 12, 12);
        step();
        vga.hit = 1'b1;
        step();
        vga.hit = 1'b0;
        chk("t3_locked", vga.aliveCount, 39);
        sof();
        set_pix(1, 3, 12, 12);
        step();
        vga.hit = 1'b1;
        step();
        vga.hit = 1'b0;
        chk("t3_nodraw_ignored", vga.aliveCount, 39);
        kill(2, 5);
        chk("t3_cnt_38", vga.aliveCount, 38);

        // 4: live column edges follow frame starts
        for (int r = 0; r < 4; r++) kill(r, 0);
        chk("t4_left_stale", vga.leftCol, 0);
        sof();
        chk("t4_left_1",  vga.leftCol, 1);
        chk("t4_right_9", vga.rightCol, 9);
        for (int r = 0; r < 4; r++) kill(r, 9);
        chk("t4_right_stale", vga.rightCol, 9);
        sof();
        chk("t4_right_8", vga.rightCol, 8);
        chk("t4_cnt_30",  vga.aliveCount, 30);

        // 5: kill the rest; allDead rises with the last kill
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 10; c++) begin
                if (alive_m[r][c]) begin
                    if (exp_cnt == 1) chk("t5_not_dead_yet", vga.allDead, 0);
                    kill(r, c);
                    chk("t5_cnt", vga.aliveCount, exp_cnt);
                end
            end
        end
        chk("t5_all_dead", vga.allDead, 1);
        sof();
        chk("t5_left_hold",  vga.leftCol, 8);
        chk("t5_right_hold", vga.rightCol, 8);
        vga.newWave = 1'b1; vga.hit = 1'b1;
        step();
        vga.newWave = 1'b0; vga.hit = 1'b0;
        model_reset();
        chk("t5_nw_cnt",   vga.aliveCount, 40);
        chk("t5_nw_dead",  vga.allDead, 0);
        chk("t5_nw_left",  vga.leftCol, 0);
        chk("t5_nw_right", vga.rightCol, 9);
        set_pix(0, 0, 12, 12);
        step();
        chk("t5_nw_draw", vga.drawingRequest, 1);
        vga.newWave = 1'b1; vga.hit = 1'b1;
        step();
        vga.newWave = 1'b0; vga.hit = 1'b0;
        chk("t5_nw_beats_hit", vga.aliveCount, 40);
        step();
        chk("t5_cell_alive", vga.drawingRequest, 1);
        vga.hit = 1'b1;
        step();
        vga.hit = 1'b0;
        chk("t5_lock_cleared", vga.aliveCount, 39);
        vga.newWave = 1'b1;
        step();
        vga.newWave = 1'b0;
        chk("t5_nw2_cnt", vga.aliveCount, 40);

        // 6: animation toggles after 15 frame starts, then async reset mid-scan
        set_pix(0, 0, 5, 9);
        step();
        chk("t6_f0_draw", vga.drawingRequest, 1);
        repeat (14) sof();
        step();
        chk("t6_f0_after14", vga.drawingRequest, 1);
        sof();
        step();
        chk("t6_f1_transp", vga.drawingRequest, 0);
        chk("t6_f1_rgb_ff", vga.RGBout, 8'hFF);
        set_pix(0, 0, 10, 5);
        step();
        chk("t6_f1_draw", vga.drawingRequest, 1);
        chk("t6_f1_rgb",  vga.RGBout, 8'hE0);
        kill(1, 1);
        chk("t6_cnt_39", vga.aliveCount, 39);
        set_pix(3, 2, 10, 10);
        step();
        chk("t6_pre_rst_draw", vga.drawingRequest, 1);
        chk("t6_row3_rgb",     vga.RGBout, 8'hFC);
        #2;
        resetN = 1'b0;
        #1;
        chk("t6_rst_draw",  vga.drawingRequest, 0);
        chk("t6_rst_rgb",   vga.RGBout, 8'hFF);
        chk("t6_rst_cnt",   vga.aliveCount, 40);
        chk("t6_rst_dead",  vga.allDead, 0);
        chk("t6_rst_right", vga.rightCol, 9);
        @(negedge clk);
        resetN = 1'b1;
        model_reset();
        set_pix(1, 1, 5, 9);
        step();
        chk("t6_post_rst_draw", vga.drawingRequest, 1);
        chk("t6_post_rst_rgb",  vga.RGBout, 8'h1C);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
